// File: rtl/seg7_bcd_counter.sv
// Up/down BCD event counter (0..COUNT_MAX) with a prescaled tick, parallel
// BCD load, wrap pulse and a 4-digit multiplexed seven-segment driver.
// The count lives as four BCD digits, so comparisons against the ceiling are
// plain unsigned compares of the packed digits.
module seg7_bcd_counter #(
  parameter int TICK_DIV  = 100_000_000,
  parameter int COUNT_MAX = 99,
  parameter int SCAN_BITS = 20,
  parameter int BLANK_LZ  = 1
) (
  input  logic        clk,
  input  logic        btnC,
  input  logic        en,
  input  logic        up,
  input  logic        load,
  input  logic [15:0] load_bcd,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        wrap
);

  localparam int             PW       = $clog2(TICK_DIV);
  localparam logic [PW-1:0]  PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [15:0]    MAX_BCD  = {4'((COUNT_MAX / 1000) % 10), 4'((COUNT_MAX / 100) % 10),
                                         4'((COUNT_MAX / 10) % 10),   4'(COUNT_MAX % 10)};

  logic [PW-1:0]        pre_q, pre_d;
  logic [3:0][3:0]      d_q, d_d, inc, dec;
  logic                 wrap_q, wrap_d;
  logic [SCAN_BITS-1:0] scan_q;
  logic [3:0]           an_q, an_d;
  logic [6:0]           seg_q, seg_d;
  logic                 tick, load_ok, bcd_ok, cy, bw;
  logic [1:0]           sel;
  logic [3:0]           digit;
  logic [3:0]           lz;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  assign tick = en && (pre_q == PRE_LAST);

  // Load qualification: every nibble a decimal digit and the value within range.
  always_comb begin
    bcd_ok = 1'b1;
    for (int i = 0; i < 4; i++)
      if (load_bcd[4*i +: 4] > 4'd9) bcd_ok = 1'b0;
    load_ok = load && bcd_ok && (load_bcd <= MAX_BCD);
  end

  // BCD +1 / -1 with ripple carry and borrow across the digits.
  always_comb begin
    inc = d_q;
    dec = d_q;
    cy  = 1'b1;
    bw  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (cy) begin
        if (d_q[i] == 4'd9) inc[i] = 4'd0;
        else begin
          inc[i] = d_q[i] + 4'd1;
          cy     = 1'b0;
        end
      end
      if (bw) begin
        if (d_q[i] == 4'd0) dec[i] = 4'd9;
        else begin
          dec[i] = d_q[i] - 4'd1;
          bw     = 1'b0;
        end
      end
    end
  end

  // Next count / prescaler / wrap: load beats tick; an invalid load lets the tick through.
  always_comb begin
    pre_d  = pre_q;
    d_d    = d_q;
    wrap_d = 1'b0;
    if (load_ok) begin
      d_d   = load_bcd;
      pre_d = '0;
    end else begin
      if (en) pre_d = tick ? '0 : pre_q + PW'(1);
      if (tick) begin
        if (up) begin
          if (d_q == MAX_BCD) begin
            d_d    = '0;
            wrap_d = 1'b1;
          end else d_d = inc;
        end else begin
          if (d_q == 16'h0000) begin
            d_d    = MAX_BCD;
            wrap_d = 1'b1;
          end else d_d = dec;
        end
      end
    end
  end

  // Display select, leading-zero blanking and segment decode.
  always_comb begin
    sel   = scan_q[SCAN_BITS-1 -: 2];
    digit = d_q[~sel];
    lz[3] = (d_q[3] == 4'd0);
    lz[2] = lz[3] && (d_q[2] == 4'd0);
    lz[1] = lz[2] && (d_q[1] == 4'd0);
    lz[0] = 1'b0;
    an_d  = ~(4'b1000 >> sel);
    seg_d = ((BLANK_LZ != 0) && lz[~sel]) ? 7'b1111111 : seg7(digit);
  end

  // Counter state and wrap pulse.
  always_ff @(posedge clk) begin
    if (btnC) begin
      pre_q  <= '0;
      d_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      d_q    <= d_d;
      wrap_q <= wrap_d;
    end
  end

  // Free-running scan counter and registered display outputs.
  always_ff @(posedge clk) begin
    if (btnC) begin
      scan_q <= '0;
      an_q   <= 4'b1111;
      seg_q  <= 7'b1111111;
    end else begin
      scan_q <= scan_q + SCAN_BITS'(1);
      an_q   <= an_d;
      seg_q  <= seg_d;
    end
  end

  assign an   = an_q;
  assign seg  = seg_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_seg7_bcd_counter.sv
// Directed bench for seg7_bcd_counter with TICK_DIV=4, SCAN_BITS=4,
// COUNT_MAX=12. A second instance with BLANK_LZ=0 shares all inputs.
module tb_seg7_bcd_counter;

  logic        clk = 1'b0;
  logic        btnC, en, up, load;
  logic [15:0] load_bcd;
  logic [3:0]  an, an0;
  logic [6:0]  seg, seg0;
  logic        wrap, wrap0;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        ld;
    logic [15:0] bcd;
    logic        en;
    logic        up;
    logic [15:0] cnt;
    logic        wrap;
  } vec_t;

  vec_t vec[34];

  seg7_bcd_counter #(.TICK_DIV(4), .COUNT_MAX(12), .SCAN_BITS(4), .BLANK_LZ(1)) dut (
    .clk(clk), .btnC(btnC), .en(en), .up(up), .load(load), .load_bcd(load_bcd),
    .an(an), .seg(seg), .wrap(wrap));

  seg7_bcd_counter #(.TICK_DIV(4), .COUNT_MAX(12), .SCAN_BITS(4), .BLANK_LZ(0)) dut0 (
    .clk(clk), .btnC(btnC), .en(en), .up(up), .load(load), .load_bcd(load_bcd),
    .an(an0), .seg(seg0), .wrap(wrap0));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset both instances, load a value with en=0, then walk one full refresh.
  task automatic disp_pass(input logic [15:0] bcd,
                           input logic [6:0] b0, input logic [6:0] b1,
                           input logic [6:0] b2, input logic [6:0] b3,
                           input logic [6:0] z0, input logic [6:0] z1,
                           input logic [6:0] z2, input logic [6:0] z3);
    logic [6:0] eb, ez;
    logic [3:0] ea;
    int s;
    btnC = 1'b1; load = 1'b0; en = 1'b0;
    step(); step();
    chk("disp_rst_an", 16'(an), 16'hF);
    chk("disp_rst_seg", 16'(seg), 16'h7F);
    btnC = 1'b0; load = 1'b1; load_bcd = bcd;
    for (int k = 1; k <= 16; k++) begin
      step();
      load = 1'b0;
      s  = ((k - 1) / 4) % 4;
      ea = ~(4'b1000 >> s);
      eb = (s == 0) ? b0 : (s == 1) ? b1 : (s == 2) ? b2 : b3;
      ez = (s == 0) ? z0 : (s == 1) ? z1 : (s == 2) ? z2 : z3;
      chk("disp_an", 16'(an), 16'(ea));
      chk("disp_seg", 16'(seg), 16'(eb));
      chk("disp_an_nolz", 16'(an0), 16'(ea));
      chk("disp_seg_nolz", 16'(seg0), 16'(ez));
    end
  endtask

  initial begin
    btnC = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_bcd = 16'h0000;

    // row: ld, bcd, en, up, expected count, expected wrap
    vec[0]  = '{1'b1, 16'h0009, 1'b1, 1'b1, 16'h0009, 1'b0};
    vec[1]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0009, 1'b0};
    vec[2]  = '{1'b1, 16'h0013, 1'b1, 1'b1, 16'h0009, 1'b0};
    vec[3]  = '{1'b1, 16'h000A, 1'b1, 1'b1, 16'h0009, 1'b0};
    vec[4]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0010, 1'b0};
    vec[5]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0010, 1'b0};
    vec[6]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0010, 1'b0};
    vec[7]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0010, 1'b0};
    vec[8]  = '{1'b1, 16'h0005, 1'b1, 1'b1, 16'h0005, 1'b0};
    vec[9]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0005, 1'b0};
    vec[10] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0005, 1'b0};
    vec[11] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0005, 1'b0};
    vec[12] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0006, 1'b0};
    vec[13] = '{1'b1, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0};
    vec[14] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0};
    vec[15] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0};
    vec[16] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0};
    vec[17] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0012, 1'b1};
    vec[18] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0012, 1'b0};
    vec[19] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0012, 1'b0};
    vec[20] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0012, 1'b0};
    vec[21] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0011, 1'b0};
    vec[22] = '{1'b1, 16'h0010, 1'b1, 1'b0, 16'h0010, 1'b0};
    vec[23] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0010, 1'b0};
    vec[24] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0010, 1'b0};
    vec[25] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0010, 1'b0};
    vec[26] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0009, 1'b0};
    vec[27] = '{1'b1, 16'h0012, 1'b1, 1'b1, 16'h0012, 1'b0};
    vec[28] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0012, 1'b0};
    vec[29] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0012, 1'b0};
    vec[30] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0012, 1'b0};
    vec[31] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b1};
    vec[32] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b0};
    vec[33] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b0};

    // Reset state
    step(); step();
    chk("rst_cnt", dut.d_q, 16'h0000);
    chk("rst_wrap", 16'(wrap), 16'h0);
    chk("rst_an", 16'(an), 16'hF);
    chk("rst_seg", 16'(seg), 16'h7F);

    // Free run up through the ceiling and one wrap
    btnC = 1'b0; en = 1'b1; up = 1'b1;
    for (int n = 1; n <= 56; n++) begin
      step();
      chk("run_cnt", dut.d_q, to_bcd((n / 4) % 13));
      chk("run_wrap", 16'(wrap), 16'(n == 52));
    end

    // Table: loads, ripple carry/borrow, wraps (pre=0, count=1 on entry)
    for (int i = 0; i < 34; i++) begin
      load = vec[i].ld; load_bcd = vec[i].bcd; en = vec[i].en; up = vec[i].up;
      step();
      chk($sformatf("vec%0d_cnt", i), dut.d_q, vec[i].cnt);
      chk($sformatf("vec%0d_wrap", i), 16'(wrap), 16'(vec[i].wrap));
    end
    load = 1'b0;

    // Pause at pre=2 for 10 cycles, then the tick lands on the 2nd edge
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("pause_cnt", dut.d_q, 16'h0000);
      chk("pause_wrap", 16'(wrap), 16'h0);
    end
    en = 1'b1;
    step();
    chk("resume1_cnt", dut.d_q, 16'h0000);
    step();
    chk("resume2_cnt", dut.d_q, 16'h0001);

    // Display: 0007, 0010, 0000 with and without leading-zero blanking
    disp_pass(16'h0007, 7'h7F, 7'h7F, 7'h7F, 7'h78, 7'h40, 7'h40, 7'h40, 7'h78);
    disp_pass(16'h0010, 7'h7F, 7'h7F, 7'h79, 7'h40, 7'h40, 7'h40, 7'h79, 7'h40);
    disp_pass(16'h0000, 7'h7F, 7'h7F, 7'h7F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40);

    // Reset mid-count at 0011 with pre=3
    en = 1'b1; up = 1'b1; load = 1'b1; load_bcd = 16'h0011;
    step();
    load = 1'b0;
    step(); step(); step();
    chk("pre_mid_cnt", dut.d_q, 16'h0011);
    btnC = 1'b1;
    step();
    chk("midrst_cnt", dut.d_q, 16'h0000);
    chk("midrst_wrap", 16'(wrap), 16'h0);
    chk("midrst_an", 16'(an), 16'hF);
    chk("midrst_seg", 16'(seg), 16'h7F);
    step();
    chk("midrst_hold_cnt", dut.d_q, 16'h0000);
    chk("midrst_hold_an", 16'(an), 16'hF);
    btnC = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      step();
      chk("postrst_cnt", dut.d_q, (n == 4) ? 16'h0001 : 16'h0000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
